imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch request/response interface.
- Accepts one fetch request at a time and waits a programmable number of cycles.
- Returns the 32-bit instruction word, or a fault, to fetch; holds the response until fetch accepts it.
- Backed by a word-addressed array; a side load port (bootloader/testbench) writes program contents.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
- LATENCY, 1, cycles from request acceptance to o_rsp_valid (legal 1..15).

Ports:
- i_clk  in  1  CPU clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  1  fetch request present.
- i_req_addr  in  32  byte PC of request.
- o_req_ready  out  1  responder can accept a request.
- i_flush  in  1  cancel any outstanding request/response.
- o_rsp_valid  out  1  response present.
- o_rsp_inst  out  32  instruction word.
- o_rsp_fault  out  1  response is a fault.
- o_rsp_cause  out  4  RISC-V exception cause: 0 = misaligned, 1 = access fault.
- i_rsp_ready  in  1  fetch accepts response (low = stall).
- i_ld_we  in  1  load-port write enable.
- i_ld_addr  in  32  load-port byte address (word aligned; [1:0] ignored).
- i_ld_data  in  32  load-port write data.

Behaviour:
- Clock/reset: one clock, i_clk. i_rst_n is synchronous and active-low.
- Reset values: state IDLE, o_rsp_valid=0, o_rsp_inst=32'h0000_0013 (NOP), o_rsp_fault=0, o_rsp_cause=0, wait counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- o_req_ready=1 only in IDLE, including during the reset-released cycle.
- Accept: in IDLE, when i_req_valid && !i_flush, latch addr, load counter with LATENCY-1, go to WAIT.
- WAIT: decrement counter each cycle. When counter==0, register the response into the outputs and go to RESP.
  - Result: accepted at edge T gives o_rsp_valid high after edge T+LATENCY.
- Response classification:
  - addr[1:0]!=0: fault=1, cause=0, inst=NOP.
  - Else, addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): fault=1, cause=1, inst=NOP.
  - Else: fault=0, cause=0, inst=array[(addr-BASE_ADDR)>>2].
  - Misaligned takes priority over out-of-range.
  - Faults observe the same latency as normal responses.
- RESP: outputs held stable while i_rsp_ready=0. On i_rsp_ready=1, go to IDLE with o_rsp_valid=0 next cycle.
  - No back-to-back acceptance in the handoff cycle: throughput is at most one request per LATENCY+2 cycles.
- Flush: i_flush=1 in WAIT or RESP goes to IDLE next cycle with o_rsp_valid=0; the response is discarded and never presented.
  - i_flush in IDLE with i_req_valid: request is not accepted.
  - Flush has priority over i_rsp_ready and over counter expiry.
- Load port: in-range i_ld_we writes the array at posedge, in any state. Out-of-range writes are dropped.
  - Write to the word being captured in the same cycle: response carries the old data (read-before-write).
  - Writes to the latched word in earlier WAIT cycles are visible.
- Reset mid-operation: pending request is dropped, outputs return to reset values next cycle.
- Address arithmetic: 32-bit unsigned compare/subtract, no wrap; an address below BASE_ADDR is an access fault.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE/WAIT/RESP, 2 bits).
  - NOP constant 32'h0000_0013.
  - Cause codes CAUSE_INST_MISALIGNED=0 and CAUSE_INST_ACCESS=1.
- One sub-module, imem_array: single read port and single write port, synchronous write, combinational word read indexed by word address, DEPTH_WORDS parameter.
- FSM, counter and address check stay in imem_responder.

Test Plan:
- Basic read: load word 0x00500093 at addr 0x0, LATENCY=1, request addr 0x0 at T -> o_req_ready drops, o_rsp_valid=1 at T+1 with inst=0x00500093, fault=0.
- Stall/latency: LATENCY=3, request 0x4 holding 0x00100113, i_rsp_ready=0 for 4 cycles -> valid appears at T+3 and the word is held stable until ready=1; idle the next cycle.
- Misaligned: request 0x6 -> fault=1, cause=0, inst=0x00000013 after LATENCY. Request 4*DEPTH_WORDS -> fault=1, cause=1.
- Flush in WAIT: LATENCY=4, request 0x8, assert i_flush at T+2 -> o_rsp_valid never rises, o_req_ready=1 at T+3. A new request 0xC returns its word normally.
- Flush in RESP plus same-cycle request in IDLE: flush while valid -> valid=0 next cycle. Flush with i_req_valid in IDLE -> not accepted.
- Reset mid-WAIT: assert i_rst_n=0 one cycle during WAIT -> o_rsp_valid=0, inst=NOP, ready=1 after release; array contents preserved, so re-read returns the loaded value.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// FSM encoding, NOP filler and fetch exception cause codes.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [3:0] CAUSE_INST_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_INST_ACCESS     = 4'd1;

endpackage

// File: rtl/imem_responder_array.sv
// Word-addressed instruction storage: one synchronous write port
// and one combinational read port. Contents are not reset.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory-side end of the fetch interface: accepts one request,
// waits LATENCY cycles, then holds the word or fault until taken.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        o_req_ready,
    input  logic        i_flush,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_inst,
    output logic        o_rsp_fault,
    output logic [3:0]  o_rsp_cause,
    input  logic        i_rsp_ready,
    input  logic        i_ld_we,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    // Unsigned, non-wrapping window check against the mapped region.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_inst_q, rsp_inst_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [3:0]  rsp_cause_q, rsp_cause_d;

    logic [31:0] ld_addr_w;
    logic        ld_hit;
    logic [31:0] rd_data;

    assign ld_addr_w = i_ld_addr & ~32'h3;
    assign ld_hit    = i_ld_we && in_range(ld_addr_w);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (ld_hit),
        .i_waddr (word_idx(ld_addr_w)),
        .i_wdata (i_ld_data),
        .i_raddr (word_idx(addr_q)),
        .o_rdata (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_inst_d  = rsp_inst_q;
        rsp_fault_d = rsp_fault_q;
        rsp_cause_d = rsp_cause_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid && !i_flush) begin
                    addr_d  = i_req_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    // Capture reads the array before this edge's load-port write.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    if (addr_q[1:0] != 2'b00) begin
                        rsp_inst_d  = NOP_INST;
                        rsp_fault_d = 1'b1;
                        rsp_cause_d = CAUSE_INST_MISALIGNED;
                    end else if (!in_range(addr_q)) begin
                        rsp_inst_d  = NOP_INST;
                        rsp_fault_d = 1'b1;
                        rsp_cause_d = CAUSE_INST_ACCESS;
                    end else begin
                        rsp_inst_d  = rd_data;
                        rsp_fault_d = 1'b0;
                        rsp_cause_d = CAUSE_INST_MISALIGNED;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (i_flush || i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= NOP_INST;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_inst_q  <= rsp_inst_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_inst  = rsp_inst_q;
    assign o_rsp_fault = rsp_fault_q;
    assign o_rsp_cause = rsp_cause_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a cycle-stamped reference
// model compared every negedge, plus literal per-transaction checks.
module tb_imem_responder;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        rsp_fault;
    logic [3:0]  rsp_cause;
    logic        rsp_ready;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .LATENCY     (LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .o_req_ready (req_ready),
        .i_flush     (flush),
        .o_rsp_valid (rsp_valid),
        .o_rsp_inst  (rsp_inst),
        .o_rsp_fault (rsp_fault),
        .o_rsp_cause (rsp_cause),
        .i_rsp_ready (rsp_ready),
        .i_ld_we     (ld_we),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is "busy" from acceptance until taken,
    // and becomes visible exactly LAT edges after the accepting edge.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy  = 1'b0;
    bit          m_shown = 1'b0;
    longint      cyc     = 0;
    longint      m_acc   = 0;
    logic [31:0] m_addr;
    logic [31:0] m_inst  = NOP;
    logic        m_fault = 1'b0;
    logic [3:0]  m_cause = 4'd0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_shown = 1'b0;
        end else if (flush) begin
            m_busy  = 1'b0;
            m_shown = 1'b0;
        end else if (m_shown) begin
            if (rsp_ready) begin
                m_busy  = 1'b0;
                m_shown = 1'b0;
            end
        end else if (m_busy) begin
            if (cyc - m_acc == LAT) begin
                m_shown = 1'b1;
                if (m_addr % 4 != 0) begin
                    m_inst = NOP; m_fault = 1'b1; m_cause = 4'd0;
                end else if (m_addr >= 32'(4 * DEPTH)) begin
                    m_inst = NOP; m_fault = 1'b1; m_cause = 4'd1;
                end else begin
                    m_inst = m_mem[m_addr / 4]; m_fault = 1'b0; m_cause = 4'd0;
                end
            end
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_addr = req_addr;
        end
        if (ld_we && ld_addr < 32'(4 * DEPTH)) begin
            m_mem[ld_addr / 4] = ld_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ready", 32'(req_ready), 32'(!m_busy));
            chk("model_valid", 32'(rsp_valid), 32'(m_shown));
            if (m_shown) begin
                chk("model_inst", rsp_inst, m_inst);
                chk("model_fault", 32'(rsp_fault), 32'(m_fault));
                chk("model_cause", 32'(rsp_cause), 32'(m_cause));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int stall,
                         input logic [31:0] e_inst, input logic e_fault,
                         input logic [3:0] e_cause);
        int n;
        chk("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
        chk("ready_drop", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_inst", rsp_inst, e_inst);
        chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
        chk("rsp_cause", 32'(rsp_cause), 32'(e_cause));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_inst", rsp_inst, e_inst);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("handoff_valid", 32'(rsp_valid), 32'd0);
        chk("handoff_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
        rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_inst", rsp_inst, NOP);
        chk("rst_fault", 32'(rsp_fault), 32'd0);
        chk("rst_cause", 32'(rsp_cause), 32'd0);
        rst_n = 1'b1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        tick();

        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h0010_0113);
        load(32'h8, 32'h1111_1111);
        load(32'hC, 32'h2222_2222);
        load(32'hFC, 32'hDEAD_BEEF);
        load(32'h100, 32'hBAD0_BAD0);

        fetch(32'h0, 0, 32'h0050_0093, 1'b0, 4'd0);
        fetch(32'h4, 4, 32'h0010_0113, 1'b0, 4'd0);
        fetch(32'h6, 1, NOP, 1'b1, 4'd0);
        fetch(32'h100, 0, NOP, 1'b1, 4'd1);
        fetch(32'h102, 0, NOP, 1'b1, 4'd0);
        fetch(32'hFFFF_FFFC, 0, NOP, 1'b1, 4'd1);
        fetch(32'hFC, 0, 32'hDEAD_BEEF, 1'b0, 4'd0);

        // Flush mid-WAIT: response must never appear.
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wflush_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wflush_novalid", 32'(rsp_valid), 32'd0);
        end
        fetch(32'hC, 0, 32'h2222_2222, 1'b0, 4'd0);

        // Flush on the expiry edge beats capture.
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("xflush_valid", 32'(rsp_valid), 32'd0);
        chk("xflush_ready", 32'(req_ready), 32'd1);

        // Flush in RESP wins over rsp_ready.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        repeat (LAT) tick();
        chk("rflush_pre", 32'(rsp_valid), 32'd1);
        flush = 1'b1; rsp_ready = 1'b1;
        tick();
        flush = 1'b0; rsp_ready = 1'b0;
        chk("rflush_valid", 32'(rsp_valid), 32'd0);
        chk("rflush_ready", 32'(req_ready), 32'd1);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("iflush_ready", 32'(req_ready), 32'd1);
        repeat (LAT + 1) tick();
        chk("iflush_novalid", 32'(rsp_valid), 32'd0);

        // Early-WAIT write is seen; capture-edge write is not.
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        load(32'h4, 32'h3333_3333);
        tick();
        load(32'h4, 32'h4444_4444);
        chk("rbw_valid", 32'(rsp_valid), 32'd1);
        chk("rbw_inst", rsp_inst, 32'h3333_3333);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch(32'h4, 0, 32'h4444_4444, 1'b0, 4'd0);

        // Reset mid-WAIT drops the request, keeps the array.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_inst", rsp_inst, NOP);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        repeat (LAT + 1) tick();
        chk("mrst_novalid", 32'(rsp_valid), 32'd0);
        fetch(32'h0, 0, 32'h0050_0093, 1'b0, 4'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
